audio_adc: RTL

AUDIO_ADC -- requirements
Module: audio_adc

---
 rtl/audio_pkg.sv | 13 +
 rtl/audio_adc_if.sv | 27 ++
 rtl/aud_sync.sv | 25 ++
 rtl/audio_adc.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared definitions for the I2S audio ADC receiver: default word width and FSM states.
package audio_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        StSync,
        StDelay,
        StShift,
        StHold
    } adc_state_e;

endpackage

// File: rtl/audio_adc_if.sv
// Codec serial inputs plus the sample-pair handshake and error flags of audio_adc.
interface audio_adc_if #(
    parameter int unsigned DATA_WIDTH = audio_pkg::DATA_WIDTH_DEF
);

    logic                  iAUD_BCK;
    logic                  iAUD_LRCK;
    logic                  iAUD_ADCDAT;
    logic                  iREADY;
    logic                  iCLR_ERR;
    logic [DATA_WIDTH-1:0] oLEFT;
    logic [DATA_WIDTH-1:0] oRIGHT;
    logic                  oVALID;
    logic                  oOVERRUN;
    logic                  oFRAME_ERR;

    modport master (
        output iAUD_BCK, iAUD_LRCK, iAUD_ADCDAT, iREADY, iCLR_ERR,
        input  oLEFT, oRIGHT, oVALID, oOVERRUN, oFRAME_ERR
    );

    modport slave (
        input  iAUD_BCK, iAUD_LRCK, iAUD_ADCDAT, iREADY, iCLR_ERR,
        output oLEFT, oRIGHT, oVALID, oOVERRUN, oFRAME_ERR
    );

endinterface

// File: rtl/aud_sync.sv
// Two-flop synchronizer followed by one history stage; rise_o pulses on a synced 0->1.
module aud_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o,
    output logic hist_o,
    output logic rise_o
);

    logic [2:0] sr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q <= '0;
        end else begin
            sr_q <= {sr_q[1:0], d_i};
        end
    end

    assign q_o    = sr_q[1];
    assign hist_o = sr_q[2];
    assign rise_o = sr_q[1] & ~sr_q[2];

endmodule

// File: rtl/audio_adc.sv
// I2S ADC receiver: deserialises left/right words and publishes them as a valid/ready pair.
module audio_adc
    import audio_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input logic        iCLK,
    input logic        iRST_N,
    audio_adc_if.slave bus
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);

    typedef logic [DATA_WIDTH-1:0] word_t;

    logic bck_rise;
    logic lrck_s;
    logic dat_s;
    logic bck_s_unused;
    logic bck_hist_unused;
    logic lrck_hist_unused;
    logic lrck_rise_unused;
    logic dat_hist_unused;
    logic dat_rise_unused;

    aud_sync u_sync_bck (
        .clk_i  (iCLK),
        .rst_ni (iRST_N),
        .d_i    (bus.iAUD_BCK),
        .q_o    (bck_s_unused),
        .hist_o (bck_hist_unused),
        .rise_o (bck_rise)
    );

    aud_sync u_sync_lrck (
        .clk_i  (iCLK),
        .rst_ni (iRST_N),
        .d_i    (bus.iAUD_LRCK),
        .q_o    (lrck_s),
        .hist_o (lrck_hist_unused),
        .rise_o (lrck_rise_unused)
    );

    aud_sync u_sync_dat (
        .clk_i  (iCLK),
        .rst_ni (iRST_N),
        .d_i    (bus.iAUD_ADCDAT),
        .q_o    (dat_s),
        .hist_o (dat_hist_unused),
        .rise_o (dat_rise_unused)
    );

    adc_state_e       state_q, state_d;
    logic             chan_q, chan_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    word_t            sr_q, sr_d;
    logic             lrck_prev_q, lrck_prev_d;
    logic             lrck_seen_q, lrck_seen_d;
    word_t            hold_left_q, hold_left_d;
    logic             left_pres_q, left_pres_d;
    word_t            left_q, left_d;
    word_t            right_q, right_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             ferr_q, ferr_d;

    logic             lrck_edge;
    logic             word_done;
    logic             frame_err_ev;
    logic             pair_done;
    logic             overrun_ev;
    word_t            new_word;

    // No edge is reported until one LRCK sample has been taken after reset.
    assign lrck_edge = bck_rise & lrck_seen_q & (lrck_s != lrck_prev_q);
    assign new_word  = {sr_q[DATA_WIDTH-2:0], dat_s};

    always_comb begin
        state_d      = state_q;
        chan_d       = chan_q;
        cnt_d        = cnt_q;
        sr_d         = sr_q;
        lrck_prev_d  = lrck_prev_q;
        lrck_seen_d  = lrck_seen_q;
        word_done    = 1'b0;
        frame_err_ev = 1'b0;

        if (bck_rise) begin
            lrck_prev_d = lrck_s;
            lrck_seen_d = 1'b1;
        end

        unique case (state_q)
            StSync: begin
                if (lrck_edge) begin
                    state_d = StDelay;
                    chan_d  = lrck_s;
                end
            end
            StDelay: begin
                if (lrck_edge) begin
                    chan_d = lrck_s;
                end else if (bck_rise) begin
                    state_d = StShift;
                    cnt_d   = CntW'(DATA_WIDTH);
                end
            end
            StShift: begin
                if (lrck_edge) begin
                    frame_err_ev = 1'b1;
                    chan_d       = lrck_s;
                    state_d      = StDelay;
                end else if (bck_rise) begin
                    sr_d = new_word;
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                    if (cnt_q == CntW'(1)) begin
                        word_done = 1'b1;
                        state_d   = StHold;
                    end
                end
            end
            StHold: begin
                if (lrck_edge) begin
                    state_d = StDelay;
                    chan_d  = lrck_s;
                end
            end
            default: state_d = StSync;
        endcase
    end

    always_comb begin
        hold_left_d = hold_left_q;
        left_pres_d = left_pres_q;
        left_d      = left_q;
        right_d     = right_q;
        valid_d     = valid_q;
        ovr_d       = ovr_q;
        ferr_d      = ferr_q;
        pair_done   = 1'b0;
        overrun_ev  = 1'b0;

        if (frame_err_ev) begin
            left_pres_d = 1'b0;
        end

        if (word_done) begin
            if (!chan_q) begin
                hold_left_d = new_word;
                left_pres_d = 1'b1;
            end else begin
                left_pres_d = 1'b0;
                pair_done   = left_pres_q;
            end
        end

        if (valid_q && bus.iREADY) begin
            valid_d = 1'b0;
        end

        // A pair landing on an acceptance cycle replaces the accepted one.
        if (pair_done) begin
            if (!valid_q || bus.iREADY) begin
                left_d  = hold_left_q;
                right_d = new_word;
                valid_d = 1'b1;
            end else begin
                overrun_ev = 1'b1;
            end
        end

        if (bus.iCLR_ERR) begin
            ovr_d  = 1'b0;
            ferr_d = 1'b0;
        end
        if (overrun_ev) begin
            ovr_d = 1'b1;
        end
        if (frame_err_ev) begin
            ferr_d = 1'b1;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q     <= StSync;
            chan_q      <= 1'b0;
            cnt_q       <= '0;
            sr_q        <= '0;
            lrck_prev_q <= 1'b0;
            lrck_seen_q <= 1'b0;
            hold_left_q <= '0;
            left_pres_q <= 1'b0;
            left_q      <= '0;
            right_q     <= '0;
            valid_q     <= 1'b0;
            ovr_q       <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            chan_q      <= chan_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            lrck_prev_q <= lrck_prev_d;
            lrck_seen_q <= lrck_seen_d;
            hold_left_q <= hold_left_d;
            left_pres_q <= left_pres_d;
            left_q      <= left_d;
            right_q     <= right_d;
            valid_q     <= valid_d;
            ovr_q       <= ovr_d;
            ferr_q      <= ferr_d;
        end
    end

    assign bus.oLEFT      = left_q;
    assign bus.oRIGHT     = right_q;
    assign bus.oVALID     = valid_q;
    assign bus.oOVERRUN   = ovr_q;
    assign bus.oFRAME_ERR = ferr_q;

endmodule
